leaf_stream_packetizer: RTL and testbench

LEAF_STREAM_PACKETIZER -- requirements
Module: leaf_stream_packetizer

---
 rtl/leaf_stream_packetizer_pkg.sv | 22 ++
 rtl/leaf_stream_packetizer_credit_counter.sv | 58 +++++
 rtl/leaf_stream_packetizer.sv | 144 ++++++++++++++
 tb/tb_leaf_stream_packetizer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/leaf_stream_packetizer_pkg.sv
// Shared definitions for the leaf stream packetizer: packet field positions,
// config-payload layout and the control FSM state encoding.
package leaf_stream_packetizer_pkg;

    // Default BFT packet layout: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload
    localparam int PKT_VALID_BIT = 48;
    localparam int PKT_LEAF_LSB  = 43;
    localparam int PKT_PORT_LSB  = 39;
    localparam int PKT_ADDR_LSB  = 32;

    // Payload bit 31 distinguishes config (1) from credit (0) packets
    localparam int CFG_TYPE_BIT  = 31;
    localparam int CFG_LEAF_LSB  = 4;
    localparam int CFG_PORT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_UNCFG  = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPLAY = 2'd2
    } state_e;

endpackage

// File: rtl/leaf_stream_packetizer_credit_counter.sv
// Receiver free-space tracker: adds a fixed update per credit packet, removes one
// per sent word, saturates at twice the initial credit and flags empty.
module leaf_stream_packetizer_credit_counter #(
    parameter int CREDIT_INIT = 128,
    parameter int UPDATE_SIZE = 64,
    parameter int CREDIT_BITS = $clog2(2 * CREDIT_INIT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   dec,
    output logic [CREDIT_BITS-1:0] credit,
    output logic                   zero
);

    localparam logic [CREDIT_BITS:0]   CREDIT_MAX  = (CREDIT_BITS + 1)'(2 * CREDIT_INIT);
    localparam logic [CREDIT_BITS:0]   CREDIT_UPD  = (CREDIT_BITS + 1)'(UPDATE_SIZE);
    localparam logic [CREDIT_BITS:0]   CREDIT_ONE  = (CREDIT_BITS + 1)'(1);
    localparam logic [CREDIT_BITS-1:0] CREDIT_RST  = CREDIT_BITS'(CREDIT_INIT);
    localparam logic [CREDIT_BITS-1:0] CREDIT_ZERO = CREDIT_BITS'(0);

    logic [CREDIT_BITS-1:0] credit_r;
    logic [CREDIT_BITS:0]   sum_s;
    logic [CREDIT_BITS-1:0] credit_next_s;

    // Net change for this cycle, clamped to the saturation ceiling
    always_comb begin
        sum_s = {1'b0, credit_r};
        if (inc) begin
            sum_s = sum_s + CREDIT_UPD;
        end else begin
            sum_s = sum_s;
        end
        if (dec && (credit_r != CREDIT_ZERO)) begin
            sum_s = sum_s - CREDIT_ONE;
        end else begin
            sum_s = sum_s;
        end
        if (sum_s > CREDIT_MAX) begin
            credit_next_s = CREDIT_MAX[CREDIT_BITS-1:0];
        end else begin
            credit_next_s = sum_s[CREDIT_BITS-1:0];
        end
    end

    // Credit register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_r <= CREDIT_RST;
        end else begin
            credit_r <= credit_next_s;
        end
    end

    assign credit = credit_r;
    assign zero   = (credit_r == CREDIT_ZERO);

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Wraps user words into BFT packets addressed to a configured leaf/port, gated by
// receiver credit, with a one-cycle replay of the last packet on request.
module leaf_stream_packetizer
    import leaf_stream_packetizer_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int CREDIT_INIT           = 128,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
    input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic                    vld_user2interface,
    output logic                    ack_interface2user,
    input  logic                    resend
);

    localparam int VALID_POS   = PACKET_BITS - 1;
    localparam int PORT_LSB    = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int CREDIT_BITS = $clog2(2 * CREDIT_INIT + 1);
    localparam logic [NUM_ADDR_BITS-1:0] ADDR_ONE = NUM_ADDR_BITS'(1);

    state_e                   state_r;
    state_e                   state_next_s;
    logic [NUM_LEAF_BITS-1:0] dest_leaf_r;
    logic [NUM_PORT_BITS-1:0] dest_port_r;
    logic [NUM_ADDR_BITS-1:0] addr_r;
    logic [PACKET_BITS-1:0]   last_pkt_r;
    logic [PACKET_BITS-1:0]   dout_r;
    logic                     sent_r;

    logic                     decode_s;
    logic                     is_cfg_s;
    logic                     is_credit_s;
    logic                     ack_s;
    logic                     replay_go_s;
    logic                     credit_zero_s;
    logic [CREDIT_BITS-1:0]   credit_s;
    logic [PACKET_BITS-1:0]   pkt_s;
    logic                     unused_din_s;

    // Only valid packets addressed to port 0 carry control/credit information
    assign decode_s    = din_leaf_bft2interface[VALID_POS] &&
                         (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == {NUM_PORT_BITS{1'b0}});
    assign is_cfg_s    = decode_s &&  din_leaf_bft2interface[CFG_TYPE_BIT];
    assign is_credit_s = decode_s && !din_leaf_bft2interface[CFG_TYPE_BIT];

    assign ack_s       = vld_user2interface && (state_r == ST_RUN) && !credit_zero_s && !resend;
    assign replay_go_s = (state_r == ST_RUN) && resend && sent_r;
    assign pkt_s       = {1'b1, dest_leaf_r, dest_port_r, addr_r, din_leaf_user2interface};

    // Remaining packet bits (source fields, payload middle) are not needed here
    assign unused_din_s = ^{din_leaf_bft2interface, credit_s};

    leaf_stream_packetizer_credit_counter #(
        .CREDIT_INIT (CREDIT_INIT),
        .UPDATE_SIZE (FREESPACE_UPDATE_SIZE),
        .CREDIT_BITS (CREDIT_BITS)
    ) u_credit_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (is_credit_s),
        .dec    (ack_s),
        .credit (credit_s),
        .zero   (credit_zero_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_UNCFG;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; replay lasts exactly one cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_UNCFG: begin
                if (is_cfg_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_UNCFG;
                end
            end
            ST_RUN: begin
                if (replay_go_s) begin
                    state_next_s = ST_REPLAY;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_REPLAY: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_UNCFG;
            end
        endcase
    end

    // Datapath: dout is zero unless a word is sent or the last packet is replayed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_leaf_r <= {NUM_LEAF_BITS{1'b0}};
            dest_port_r <= {NUM_PORT_BITS{1'b0}};
            addr_r      <= {NUM_ADDR_BITS{1'b0}};
            last_pkt_r  <= {PACKET_BITS{1'b0}};
            dout_r      <= {PACKET_BITS{1'b0}};
            sent_r      <= 1'b0;
        end else begin
            if (ack_s) begin
                dout_r     <= pkt_s;
                last_pkt_r <= pkt_s;
                addr_r     <= addr_r + ADDR_ONE;
                sent_r     <= 1'b1;
            end else if (replay_go_s) begin
                dout_r     <= last_pkt_r;
            end else begin
                dout_r     <= {PACKET_BITS{1'b0}};
            end
            // A new destination applies from the next word on; addr keeps counting
            if (is_cfg_s) begin
                dest_leaf_r <= din_leaf_bft2interface[CFG_LEAF_LSB +: NUM_LEAF_BITS];
                dest_port_r <= din_leaf_bft2interface[CFG_PORT_LSB +: NUM_PORT_BITS];
            end else begin
                dest_leaf_r <= dest_leaf_r;
                dest_port_r <= dest_port_r;
            end
        end
    end

    assign dout_leaf_interface2bft = dout_r;
    assign ack_interface2user      = ack_s;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Directed plus randomized bench for leaf_stream_packetizer against a
// transaction-level model of credit, addressing, destination and replay.
module tb_leaf_stream_packetizer;
    import leaf_stream_packetizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [48:0] din_bft = 49'd0;
    logic [48:0] dout;
    logic [31:0] din_user = 32'd0;
    logic        vld = 1'b0;
    logic        ack;
    logic        resend = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_cfg;
    bit          m_replay;
    bit          m_sent;
    int          m_credit;
    int          m_addr;
    logic [4:0]  m_leaf;
    logic [3:0]  m_port;
    logic [48:0] m_last;
    logic        last_ack;

    leaf_stream_packetizer dut (
        .clk                     (clk),
        .reset                   (rst),
        .din_leaf_bft2interface  (din_bft),
        .dout_leaf_interface2bft (dout),
        .din_leaf_user2interface (din_user),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .resend                  (resend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cfg = 1'b0; m_replay = 1'b0; m_sent = 1'b0;
        m_credit = 128; m_addr = 0;
        m_leaf = 5'd0; m_port = 4'd0; m_last = 49'd0;
    endtask

    function automatic logic [48:0] cfg_pkt(input logic [4:0] leaf, input logic [3:0] port);
        logic [48:0] p;
        p = 49'd0;
        p[PKT_VALID_BIT] = 1'b1;
        p[PKT_LEAF_LSB +: 5] = 5'($urandom());
        p[PKT_ADDR_LSB +: 7] = 7'($urandom());
        p[31] = 1'b1;
        p[8:4] = leaf;
        p[3:0] = port;
        return p;
    endfunction

    function automatic logic [48:0] crd_pkt(input logic [3:0] port, input logic valid);
        logic [48:0] p;
        p = {1'b0, 5'($urandom()), 4'd0, 7'($urandom()), 1'b0, 31'($urandom())};
        p[PKT_VALID_BIT] = valid;
        p[PKT_PORT_LSB +: 4] = port;
        return p;
    endfunction

    // One clock cycle, entered and left at posedge+1: drive, predict, check ack, then dout.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [48:0] bft, input logic rs);
        logic        exp_a;
        logic [48:0] exp_d;
        bit          dec;
        bit          go_replay;
        vld = v; din_user = d; din_bft = bft; resend = rs;
        dec       = bft[48] && (bft[42:39] == 4'd0);
        exp_a     = v && m_cfg && !m_replay && (m_credit > 0) && !rs;
        go_replay = m_cfg && !m_replay && rs && m_sent;
        if (exp_a)          exp_d = {1'b1, m_leaf, m_port, 7'(m_addr), d};
        else if (go_replay) exp_d = m_last;
        else                exp_d = 49'd0;
        if (exp_a) begin
            m_last = exp_d;
            m_addr = (m_addr + 1) % 128;
            m_sent = 1'b1;
        end
        m_credit = m_credit - (exp_a ? 1 : 0) + ((dec && !bft[31]) ? 64 : 0);
        if (m_credit > 256) m_credit = 256;
        if (dec && bft[31]) begin
            m_leaf = bft[8:4]; m_port = bft[3:0]; m_cfg = 1'b1;
        end
        m_replay = go_replay;
        #3;
        last_ack = ack;
        chk("ack", {48'd0, ack}, {48'd0, exp_a});
        @(posedge clk); #1;
        chk("dout", dout, exp_d);
    endtask

    task automatic stream(input int cycles, input int exp_count, input string tag);
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < cycles; i++) begin
            cycle(1'b1, $urandom(), 49'd0, 1'b0);
            if (last_ack) n_acc++;
        end
        chk(tag, 49'(n_acc), 49'(exp_count));
    endtask

    initial begin
        int r;
        logic [48:0] bft;
        model_reset();

        // Reset state with a pending user word
        vld = 1'b1; din_user = 32'hDEAD_BEEF;
        #2;
        chk("reset_dout", dout, 49'd0);
        chk("reset_ack", {48'd0, ack}, 49'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // No config: nothing accepted, resend ignored
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom(), 49'd0, (i == 2));

        // Configure leaf 3 / port 2, resend before any word is ignored
        cycle(1'b0, 32'd0, cfg_pkt(5'd3, 4'd2), 1'b0);
        cycle(1'b1, 32'h1111_1111, 49'd0, 1'b1);
        cycle(1'b1, 32'hAAAA_0001, 49'd0, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 49'd0, 1'b0);
        // Replay of B while the user keeps C valid, then C at addr 2
        cycle(1'b1, 32'hCCCC_0003, 49'd0, 1'b1);
        cycle(1'b1, 32'hCCCC_0003, 49'd0, 1'b0);
        cycle(1'b1, 32'hCCCC_0003, 49'd0, 1'b0);
        chk("replay_last", m_last, {1'b1, 5'd3, 4'd2, 7'd2, 32'hCCCC_0003});

        // Drain initial credit, then one credit packet buys 64 words
        stream(140, 125, "drain_initial");
        cycle(1'b0, 32'd0, crd_pkt(4'd0, 1'b1), 1'b0);
        stream(80, 64, "after_credit");

        // Bring credit to 1, then credit arrival with an accept nets to 64
        cycle(1'b0, 32'd0, crd_pkt(4'd0, 1'b1), 1'b0);
        stream(63, 63, "down_to_one");
        cycle(1'b1, $urandom(), crd_pkt(4'd0, 1'b1), 1'b0);
        stream(80, 64, "credit_plus_accept");

        // Ignored packets: invalid or non-zero port must not add credit
        cycle(1'b0, 32'd0, crd_pkt(4'd5, 1'b1), 1'b0);
        cycle(1'b0, 32'd0, crd_pkt(4'd0, 1'b0), 1'b0);
        stream(4, 0, "ignored_credit");

        // Reconfigure in RUN: word in the same cycle keeps old destination
        cycle(1'b0, 32'd0, crd_pkt(4'd0, 1'b1), 1'b0);
        cycle(1'b1, $urandom(), cfg_pkt(5'd9, 4'd5), 1'b0);
        stream(3, 3, "after_reconfig");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    bft = crd_pkt(4'd0, 1'b1);
                2:       bft = crd_pkt(4'($urandom_range(1, 15)), 1'b1);
                3:       bft = crd_pkt(4'd0, 1'b0);
                4:       bft = cfg_pkt(5'($urandom()), 4'($urandom()));
                default: bft = 49'd0;
            endcase
            cycle(($urandom_range(0, 3) != 0), $urandom(), bft, ($urandom_range(0, 9) == 0));
        end

        // Reset asserted while in REPLAY
        cycle(1'b0, 32'd0, crd_pkt(4'd0, 1'b1), 1'b0);
        cycle(1'b1, 32'h5555_AAAA, 49'd0, 1'b0);
        cycle(1'b1, 32'h5555_AAAA, 49'd0, 1'b1);
        chk("in_replay_dout", dout, {1'b1, m_leaf, m_port, 7'(m_addr - 1), 32'h5555_AAAA});
        rst = 1'b1;
        #1;
        chk("replay_reset_dout", dout, 49'd0);
        chk("replay_reset_ack", {48'd0, ack}, 49'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // After reset: config required, then full 128 credit from addr 0
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom(), 49'd0, 1'b0);
        cycle(1'b0, 32'd0, cfg_pkt(5'd1, 4'd7), 1'b0);
        cycle(1'b1, 32'h0000_0042, 49'd0, 1'b0);
        chk("post_reset_addr0", m_last, {1'b1, 5'd1, 4'd7, 7'd0, 32'h0000_0042});
        stream(140, 127, "post_reset_credit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
